// File: rtl/shifter_pipe.sv
// Two-stage pipelined barrel shifter (LSL/LSR/ASR/ROR) with valid/ready on both sides.
// Define SHIFTER_CARRY_EN to add the out_carry port and its pipeline registers.
module shifter_pipe #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SW    = $clog2(WIDTH),
  localparam int unsigned SPLIT = SW / 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
`ifdef SHIFTER_CARRY_EN
  ,
  output logic             out_carry
`endif
);

  localparam int unsigned SW2 = SW - SPLIT;

  typedef enum logic [1:0] {OpLsl = 2'b00, OpLsr = 2'b01, OpAsr = 2'b10, OpRor = 2'b11} op_e;

  function automatic logic [WIDTH-1:0] shift_lvl(input logic [WIDTH-1:0] d,
                                                 input int unsigned      amt,
                                                 input logic [1:0]       op,
                                                 input logic             fill);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] res;
    ones = '1;
    res  = d;
    unique case (op)
      OpLsl:   res = d << amt;
      OpLsr:   res = d >> amt;
      OpAsr:   res = (d >> amt) | (fill ? ~(ones >> amt) : '0);
      OpRor:   res = (d >> amt) | (d << (WIDTH - amt));
      default: res = d;
    endcase
    return res;
  endfunction

`ifdef SHIFTER_CARRY_EN
  // For ROR the new MSB equals d[amt-1], so it shares the right-shift carry bit.
  function automatic logic carry_lvl(input logic [WIDTH-1:0] d,
                                     input int unsigned      amt,
                                     input logic [1:0]       op);
    logic [WIDTH-1:0] t;
    t = (op == OpLsl) ? (d >> (WIDTH - amt)) : (d >> (amt - 1));
    return t[0];
  endfunction
`endif

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_data_d, s1_data_q;
  logic [SW2-1:0]   s1_shamt_q;
  logic [1:0]       s1_op_q;
  logic             s1_msb_q;
  logic [SW-1:0]    sh1;
  logic [SW2-1:0]   sh2;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_d, out_data_q;
  logic             out_zero_q;
  logic             adv2;

`ifdef SHIFTER_CARRY_EN
  logic s1_carry_d, s1_carry_q;
  logic out_carry_d, out_carry_q;
`endif

  assign adv2     = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || adv2;

  // Stage 1: levels 0..SPLIT-1 straight from the input operand.
  always_comb begin
    s1_data_d = in_data;
    sh1       = in_shamt;
`ifdef SHIFTER_CARRY_EN
    s1_carry_d = 1'b0;
`endif
    for (int unsigned k = 0; k < SPLIT; k++) begin
      if (sh1[0]) begin
`ifdef SHIFTER_CARRY_EN
        s1_carry_d = carry_lvl(s1_data_d, 1 << k, in_op);
`endif
        s1_data_d = shift_lvl(s1_data_d, 1 << k, in_op, in_data[WIDTH-1]);
      end
      sh1 = sh1 >> 1;
    end
  end

  // Stage 2: remaining levels; ASR fill comes from the registered original MSB.
  always_comb begin
    out_data_d = s1_data_q;
    sh2        = s1_shamt_q;
`ifdef SHIFTER_CARRY_EN
    out_carry_d = s1_carry_q;
`endif
    for (int unsigned j = 0; j < SW2; j++) begin
      if (sh2[0]) begin
`ifdef SHIFTER_CARRY_EN
        out_carry_d = carry_lvl(out_data_d, 1 << (SPLIT + j), s1_op_q);
`endif
        out_data_d = shift_lvl(out_data_d, 1 << (SPLIT + j), s1_op_q, s1_msb_q);
      end
      sh2 = sh2 >> 1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_shamt_q  <= '0;
      s1_op_q     <= 2'b00;
      s1_msb_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b0;
`ifdef SHIFTER_CARRY_EN
      s1_carry_q  <= 1'b0;
      out_carry_q <= 1'b0;
`endif
    end else begin
      if (adv2) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_data_q  <= out_data_d;
          out_zero_q  <= (out_data_d == '0);
`ifdef SHIFTER_CARRY_EN
          out_carry_q <= out_carry_d;
`endif
        end
      end
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_data_q  <= s1_data_d;
          s1_shamt_q <= in_shamt[SW-1:SPLIT];
          s1_op_q    <= in_op;
          s1_msb_q   <= in_data[WIDTH-1];
`ifdef SHIFTER_CARRY_EN
          s1_carry_q <= s1_carry_d;
`endif
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_zero  = out_zero_q;
`ifdef SHIFTER_CARRY_EN
  assign out_carry = out_carry_q;
`endif

endmodule

// File: tb/tb_shifter_pipe.sv
// Self-checking bench for shifter_pipe: directed 8-bit vectors, stall/reset sequences,
// and a randomized 32-bit stream against a behavioural model.
module tb_shifter_pipe;

  localparam int NV = 16;
  localparam int NR = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic       in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [7:0] in_data, out_data;
  logic [2:0] in_shamt;
  logic [1:0] in_op;

  logic        in_valid32, in_ready32, out_valid32, out_ready32, out_zero32;
  logic [31:0] in_data32, out_data32;
  logic [4:0]  in_shamt32;
  logic [1:0]  in_op32;

`ifdef SHIFTER_CARRY_EN
  logic out_carry, out_carry32;
`endif

  shifter_pipe #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
`ifdef SHIFTER_CARRY_EN
    ,
    .out_carry (out_carry)
`endif
  );

  shifter_pipe #(.WIDTH(32)) u_dut32 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .in_data   (in_data32),
    .in_shamt  (in_shamt32),
    .in_op     (in_op32),
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .out_data  (out_data32),
    .out_zero  (out_zero32)
`ifdef SHIFTER_CARRY_EN
    ,
    .out_carry (out_carry32)
`endif
  );

  typedef struct {
    logic [7:0] d;
    logic [2:0] s;
    logic [1:0] op;
    logic [7:0] q;
    logic       z;
    logic       c;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic        z;
    logic        c;
  } exp_t;

  vec_t vecs[NV];
  exp_t q_exp[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t ref32(input logic [31:0] d, input int s, input logic [1:0] op);
    exp_t e;
    logic [31:0] t;
    case (op)
      2'b00:   e.q = d << s;
      2'b01:   e.q = d >> s;
      2'b10:   e.q = 32'($signed(d) >>> s);
      default: e.q = (s == 0) ? d : ((d >> s) | (d << (32 - s)));
    endcase
    e.z = (e.q == 32'd0);
    t   = (op == 2'b00) ? (d >> (32 - s)) : (d >> (s - 1));
    e.c = (s == 0) ? 1'b0 : t[0];
    return e;
  endfunction

  task automatic drive8(input int idx);
    in_valid = 1'b1;
    in_data  = vecs[idx].d;
    in_shamt = vecs[idx].s;
    in_op    = vecs[idx].op;
  endtask

  initial begin : main
    logic xfer;
    int   acc_n, out_n;
    logic stale;
    int   sent, got;
    exp_t e;

    //            data   s     op     result z     c
    vecs[0]  = '{8'hB3, 3'd3, 2'b00, 8'h98, 1'b0, 1'b1};
    vecs[1]  = '{8'hB3, 3'd3, 2'b10, 8'hF6, 1'b0, 1'b0};
    vecs[2]  = '{8'hB3, 3'd3, 2'b01, 8'h16, 1'b0, 1'b0};
    vecs[3]  = '{8'hB3, 3'd3, 2'b11, 8'h76, 1'b0, 1'b0};
    vecs[4]  = '{8'h80, 3'd1, 2'b00, 8'h00, 1'b1, 1'b1};
    vecs[5]  = '{8'hB3, 3'd0, 2'b00, 8'hB3, 1'b0, 1'b0};
    vecs[6]  = '{8'hB3, 3'd0, 2'b10, 8'hB3, 1'b0, 1'b0};
    vecs[7]  = '{8'h5A, 3'd0, 2'b11, 8'h5A, 1'b0, 1'b0};
    vecs[8]  = '{8'h5A, 3'd0, 2'b01, 8'h5A, 1'b0, 1'b0};
    vecs[9]  = '{8'h01, 3'd7, 2'b00, 8'h80, 1'b0, 1'b0};
    vecs[10] = '{8'h80, 3'd7, 2'b10, 8'hFF, 1'b0, 1'b0};
    vecs[11] = '{8'h81, 3'd7, 2'b11, 8'h03, 1'b0, 1'b0};
    vecs[12] = '{8'h0F, 3'd4, 2'b01, 8'h00, 1'b1, 1'b1};
    vecs[13] = '{8'hC3, 3'd5, 2'b11, 8'h1E, 1'b0, 1'b0};
    vecs[14] = '{8'h70, 3'd2, 2'b10, 8'h1C, 1'b0, 1'b0};
    vecs[15] = '{8'h96, 3'd6, 2'b00, 8'h80, 1'b0, 1'b1};

    reset_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; out_ready = 1'b1;
    in_valid32 = 1'b0; in_data32 = '0; in_shamt32 = '0; in_op32 = '0; out_ready32 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_zero", 64'(out_zero), 64'd0);
`ifdef SHIFTER_CARRY_EN
    check("rst_out_carry", 64'(out_carry), 64'd0);
`endif
    reset_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back stream, out_ready=1: one result per cycle, latency 2.
    for (int i = 0; i < NV + 2; i++) begin
      @(posedge clk);
      #1;
      if (i >= 2) begin
        check($sformatf("vec%0d_valid", i - 2), 64'(out_valid), 64'd1);
        check($sformatf("vec%0d_data", i - 2), 64'(out_data), 64'(vecs[i-2].q));
        check($sformatf("vec%0d_zero", i - 2), 64'(out_zero), 64'(vecs[i-2].z));
`ifdef SHIFTER_CARRY_EN
        check($sformatf("vec%0d_carry", i - 2), 64'(out_carry), 64'(vecs[i-2].c));
`endif
      end else begin
        check($sformatf("latency_cyc%0d", i), 64'(out_valid), 64'd0);
      end
      check($sformatf("stream_in_ready%0d", i), 64'(in_ready), 64'd1);
      if (i < NV) drive8(i);
      else in_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("drain_out_valid", 64'(out_valid), 64'd0);

    // Backpressure: 4 operands, out_ready low.
    out_ready = 1'b0;
    acc_n = 0;
    out_n = 0;
    drive8(0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      xfer = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (xfer) begin
        acc_n++;
        if (acc_n < 4) drive8(acc_n);
        else in_valid = 1'b0;
      end
    end
    check("bp_accepts_stalled", 64'(acc_n), 64'd2);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_hold_data0", 64'(out_data), 64'(vecs[0].q));
    @(posedge clk);
    #1;
    check("bp_hold_data1", 64'(out_data), 64'(vecs[0].q));
    out_ready = 1'b1;
    for (int c = 0; c < 20 && out_n < 4; c++) begin
      @(negedge clk);
      xfer = in_valid && in_ready;
      if (out_valid && out_ready) begin
        check($sformatf("bp_result%0d", out_n), 64'(out_data), 64'(vecs[out_n].q));
        out_n++;
      end
      @(posedge clk);
      #1;
      if (xfer) begin
        acc_n++;
        if (acc_n < 4) drive8(acc_n);
        else in_valid = 1'b0;
      end
    end
    check("bp_accepts_total", 64'(acc_n), 64'd4);
    check("bp_results_total", 64'(out_n), 64'd4);
    check("bp_no_duplicate", 64'(out_valid), 64'd0);

    // Reset with two operands in flight.
    out_ready = 1'b0;
    drive8(4);
    @(posedge clk);
    #1;
    drive8(5);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    check("midrst_out_zero", 64'(out_zero), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      stale = stale | out_valid;
    end
    check("post_rst_no_stale", 64'(stale), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Randomized 32-bit stream with random in_valid/out_ready.
    sent = 0;
    got = 0;
    for (int c = 0; c < 40000 && got < NR; c++) begin
      @(negedge clk);
      xfer = in_valid32 && in_ready32;
      if (xfer) q_exp.push_back(ref32(in_data32, int'(in_shamt32), in_op32));
      if (out_valid32 && out_ready32) begin
        got++;
        if (q_exp.size() == 0) begin
          checks++;
          $display("FAIL rnd_spurious: got %0h expected no result", out_data32);
        end else begin
          e = q_exp.pop_front();
          check($sformatf("rnd%0d", got), 64'({out_zero32, out_data32}), 64'({e.z, e.q}));
`ifdef SHIFTER_CARRY_EN
          check($sformatf("rnd%0d_carry", got), 64'(out_carry32), 64'(e.c));
`endif
        end
      end
      @(posedge clk);
      #1;
      if (xfer) sent++;
      if (!in_valid32 || xfer) begin
        if (sent < NR) begin
          in_valid32 = ($urandom_range(0, 3) != 0);
          in_data32  = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom;
          in_shamt32 = 5'($urandom_range(0, 31));
          in_op32    = 2'($urandom_range(0, 3));
        end else begin
          in_valid32 = 1'b0;
        end
      end
      out_ready32 = ($urandom_range(0, 3) != 0);
    end
    check("rnd_results_total", 64'(got), 64'(NR));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
